aes_key_schedule_ctrl: RTL and testbench
========================================

Name: aes_key_schedule_ctrl

Overview:
Sequencer that drives one shared aes_key_expansion engine through all 10 AES-128 rounds from a single start pulse. It issues each round request with the correct rcon index and feeds every result back as the next input. It stores the 11 round keys (round 0 = cipher key) in an internal key store. The cipher round datapath reads the stored keys through a registered read port, so the expansion engine is sequenced only once per key load.

Parameters:
NUM_ROUNDS, 10, number of expansion rounds; round keys stored = NUM_ROUNDS+1
TIMEOUT, 64, maximum cycles to wait for engine ready per round before abort (range 2..255)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
start_in  input  1  one-cycle pulse; begin expansion of key_in
key_in  input  128  cipher key, sampled on the cycle start_in is accepted
busy_out  output  1  high from start acceptance until done/abort
done_out  output  1  one-cycle pulse when round key NUM_ROUNDS has been stored
keys_valid_out  output  1  key store holds a complete schedule
error_out  output  1  one-cycle pulse on engine timeout
rd_addr_in  input  4  round key index 0..NUM_ROUNDS
rd_key_out  output  128  registered round key for rd_addr_in
exp_start_out  output  1  start pulse to aes_key_expansion start_in
exp_rcon_out  output  4  to aes_key_expansion rcon_in
exp_key_out  output  128  to aes_key_expansion key_in
exp_key_in  input  128  from aes_key_expansion key_expansion_out
exp_ready_in  input  1  from aes_key_expansion key_expansion_ready_out

Behaviour:
- Reset (async, reset_n=0): state IDLE; busy_out, done_out, keys_valid_out, error_out, exp_start_out = 0; exp_rcon_out=0; exp_key_out=0; rd_key_out=0; round counter=0; wait counter=0. Key store contents are not reset but are unusable because keys_valid_out=0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - start_in=1 writes key_in to slot 0, clears keys_valid_out, sets busy_out, sets round=1, and goes to ISSUE.
- ISSUE (one cycle):
  - Registered outputs: exp_start_out=1, exp_key_out=slot[round-1], exp_rcon_out=round-1. Round 1 uses rcon 0, round 10 uses rcon 9.
  - Clears the wait counter and goes to WAIT.
  - exp_start_out is high for exactly one cycle per round.
- WAIT:
  - exp_start_out=0; the wait counter increments each cycle.
  - exp_ready_in=1 writes exp_key_in to slot[round]. If round==NUM_ROUNDS, go to DONE; otherwise round++ and go to ISSUE.
  - If the wait counter reaches TIMEOUT without ready, pulse error_out, clear busy_out, leave keys_valid_out=0, and go to IDLE.
  - exp_ready_in is ignored in every state except WAIT.
- DONE (one cycle): done_out=1, keys_valid_out=1, busy_out=0, then go to IDLE.
- start_in while busy_out=1 is ignored; there is no queueing and no restart.
- start_in in the DONE cycle is ignored. It is accepted in IDLE from the following cycle onward.
- A new start in IDLE invalidates the previous schedule immediately. keys_valid_out falls on the cycle after acceptance.
- Read port, 1-cycle latency:
  - rd_key_out <= slot[rd_addr_in] when rd_addr_in <= NUM_ROUNDS; rd_addr_in 11..15 returns 0.
  - Reads are always permitted. Data is guaranteed only while keys_valid_out=1.
  - A read of the slot being written in the same cycle returns the old content.
- Reset asserted mid-expansion aborts immediately: all outputs return to reset values, and there is no done_out or error_out pulse.
- End-to-end latency from start acceptance to done_out = sum over rounds of (engine latency + 2) + 1 cycles.

Test Plan:
- Reset then start, key_in=5468617473206D79204B756E67204675, real aes_key_expansion attached -> exactly 10 exp_start_out pulses with rcon 0..9; after done_out, rd_addr 0 gives 5468617473206D79204B756E67204675, rd_addr 1 gives E232FCF191129188B159E4E6D679A293, rd_addr 10 gives 28FDDEF86DA4244ACCC0A4FE3B316F26.
- FIPS-197 key 2B7E151628AED2A6ABF7158809CF4F3C -> after done_out, rd_addr 10 gives D014F9A8C9EE2589E13F0CC8B6630CA6; keys_valid_out=1; single done_out pulse.
- start_in pulsed again during round 4 with a different key -> ignored; final schedule matches the first key; only one done_out.
- Engine stub never asserts ready -> error_out pulses exactly TIMEOUT cycles after the ISSUE of round 1; busy_out=0; keys_valid_out=0; a subsequent start completes normally.
- reset_n low during round 6, then released and started -> no done_out/error_out during abort; outputs at reset values; new expansion from round 1 with rcon 0.
- Valid schedule then rd_addr 11, 15 -> rd_key_out=0 one cycle later; new start -> keys_valid_out low one cycle after acceptance.

Source files
------------

// File: rtl/aes_key_schedule_ctrl.sv
// aes_key_schedule_ctrl
//
// Sequences one shared aes_key_expansion engine through NUM_ROUNDS rounds
// after a single start pulse. Round results are fed back as the next request
// and every round key (slot 0 = cipher key) is kept in an internal key store.
// The cipher datapath reads the store through a registered read port.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start_in, key_in    start pulse and cipher key (sampled on acceptance)
//   busy_out            expansion in progress
//   done_out            one-cycle pulse once the last round key is stored
//   keys_valid_out      key store holds a complete schedule
//   error_out           one-cycle pulse when the engine never became ready
//   rd_addr_in          round key index to read (0..NUM_ROUNDS)
//   rd_key_out          registered round key, zero for out-of-range indices
//   exp_start_out       start pulse to the expansion engine
//   exp_rcon_out        rcon index to the expansion engine
//   exp_key_out         previous round key to the expansion engine
//   exp_key_in          expanded key from the engine
//   exp_ready_in        engine result valid
module aes_key_schedule_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start_in,
  input  logic [127:0] key_in,
  output logic         busy_out,
  output logic         done_out,
  output logic         keys_valid_out,
  output logic         error_out,
  input  logic [3:0]   rd_addr_in,
  output logic [127:0] rd_key_out,
  output logic         exp_start_out,
  output logic [3:0]   exp_rcon_out,
  output logic [127:0] exp_key_out,
  input  logic [127:0] exp_key_in,
  input  logic         exp_ready_in
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);
  // Last wait-counter value before giving up on the engine.
  localparam logic [7:0] WaitLast  = 8'(TIMEOUT - 1);

  logic [1:0]   state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   wait_q, wait_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         valid_q, valid_d;
  logic         error_q, error_d;
  logic         exp_start_q, exp_start_d;
  logic [3:0]   exp_rcon_q, exp_rcon_d;
  logic [127:0] exp_key_q, exp_key_d;
  logic [127:0] rd_key_q, rd_key_d;

  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [127:0] wr_data;

  // Key store is deliberately not reset; keys_valid_out qualifies its content.
  logic [127:0] key_store_q [NUM_ROUNDS+1];

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    wait_d      = wait_q;
    busy_d      = busy_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    exp_start_d = 1'b0;
    exp_rcon_d  = exp_rcon_q;
    exp_key_d   = exp_key_q;
    wr_en       = 1'b0;
    wr_addr     = round_q;
    wr_data     = exp_key_in;

    case (state_q)
      StIdle: begin
        if (start_in) begin
          wr_en   = 1'b1;
          wr_addr = 4'd0;
          wr_data = key_in;
          valid_d = 1'b0;
          busy_d  = 1'b1;
          round_d = 4'd1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        exp_start_d = 1'b1;
        exp_key_d   = key_store_q[round_q - 4'd1];
        exp_rcon_d  = round_q - 4'd1;
        wait_d      = 8'd0;
        state_d     = StWait;
      end
      StWait: begin
        wait_d = wait_q + 8'd1;
        // A result arriving on the last allowed cycle still wins over timeout.
        if (exp_ready_in) begin
          wr_en = 1'b1;
          if (round_q == LastRound) begin
            done_d  = 1'b1;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = StDone;
          end else begin
            round_d = round_q + 4'd1;
            state_d = StIssue;
          end
        end else if (wait_q == WaitLast) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Out-of-range indices read as zero rather than aliasing a slot.
  always_comb begin
    rd_key_d = '0;
    if (rd_addr_in <= LastRound) begin
      rd_key_d = key_store_q[rd_addr_in];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      round_q     <= 4'd0;
      wait_q      <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      exp_start_q <= 1'b0;
      exp_rcon_q  <= 4'd0;
      exp_key_q   <= '0;
      rd_key_q    <= '0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      wait_q      <= wait_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
      exp_start_q <= exp_start_d;
      exp_rcon_q  <= exp_rcon_d;
      exp_key_q   <= exp_key_d;
      rd_key_q    <= rd_key_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      key_store_q[wr_addr] <= wr_data;
    end
  end

  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign keys_valid_out = valid_q;
  assign error_out      = error_q;
  assign rd_key_out     = rd_key_q;
  assign exp_start_out  = exp_start_q;
  assign exp_rcon_out   = exp_rcon_q;
  assign exp_key_out    = exp_key_q;

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Self-checking bench for aes_key_schedule_ctrl with a behavioural AES-128
// key expansion engine and a reference schedule computed from FIPS-197 rules.
module tb_aes_key_schedule_ctrl;

  localparam int TO = 20;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start_in = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy_out, done_out, keys_valid_out, error_out;
  logic [3:0]   rd_addr_in = 4'd0;
  logic [127:0] rd_key_out;
  logic         exp_start_out;
  logic [3:0]   exp_rcon_out;
  logic [127:0] exp_key_out;
  logic [127:0] exp_key_in = '0;
  logic         exp_ready_in = 1'b0;

  aes_key_schedule_ctrl #(
    .NUM_ROUNDS(10),
    .TIMEOUT   (TO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start_in      (start_in),
    .key_in        (key_in),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .keys_valid_out(keys_valid_out),
    .error_out     (error_out),
    .rd_addr_in    (rd_addr_in),
    .rd_key_out    (rd_key_out),
    .exp_start_out (exp_start_out),
    .exp_rcon_out  (exp_rcon_out),
    .exp_key_out   (exp_key_out),
    .exp_key_in    (exp_key_in),
    .exp_ready_in  (exp_ready_in)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // ---------------- AES-128 key expansion reference ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] v);
    logic [7:0] inv, r, s;
    inv = 8'h00;
    if (v != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, v);
    end
    r = inv; s = inv;
    for (int k = 0; k < 4; k++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [3:0] ri);
    logic [7:0]  rc;
    logic [31:0] rot, t, w0, w1, w2, w3;
    rc = 8'h01;
    for (int i = 0; i < int'(ri); i++) rc = xtime(rc);
    rot = {k[23:0], k[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
    w0  = k[127:96] ^ t;
    w1  = k[95:64] ^ w0;
    w2  = k[63:32] ^ w1;
    w3  = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // ---------------- Engine model and monitor ----------------
  int           eng_mode = 1;  // 0 never ready, 1 normal, 2 ready stuck high
  int           lat_max = 3;
  int           eng_cnt = 0;
  logic [127:0] eng_res;
  int           lat_q[$];
  logic [3:0]   rcon_q[$];
  int           n_starts = 0;
  int           n_done = 0;
  int           n_err = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      eng_cnt      = 0;
      exp_ready_in = 1'b0;
    end else if (eng_mode == 2) begin
      exp_ready_in = 1'b1;
      exp_key_in   = '1;
    end else begin
      exp_ready_in = 1'b0;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          exp_ready_in = 1'b1;
          exp_key_in   = eng_res;
        end
      end
      if (exp_start_out && eng_mode == 1) begin
        int lat;
        lat     = int'($urandom_range(lat_max, 1));
        eng_cnt = lat;
        eng_res = next_key(exp_key_out, exp_rcon_out);
        lat_q.push_back(lat);
      end
    end
  end

  always @(negedge clk) begin
    if (exp_start_out) begin
      n_starts++;
      rcon_q.push_back(exp_rcon_out);
    end
    if (done_out)  n_done++;
    if (error_out) n_err++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_starts = 0; n_done = 0; n_err = 0;
    rcon_q.delete();
    lat_q.delete();
  endtask

  task automatic read_key(input logic [3:0] addr, output logic [127:0] data);
    rd_addr_in = addr;
    tick();
    data = rd_key_out;
  endtask

  // Full expansion checked against the reference schedule. Optionally injects
  // a second start once inj_round requests have been issued, and optionally
  // pokes start_in during the done cycle.
  task automatic full_check(input logic [127:0] key, input int inj_round,
                            input logic [127:0] inj_key, input bit done_poke);
    logic [127:0] ks [11];
    logic [127:0] got;
    int cycles, exp_lat;
    bit injected;
    ks[0] = key;
    for (int r = 1; r <= 10; r++) ks[r] = next_key(ks[r-1], 4'(r - 1));
    clear_counts();
    injected = 1'b0;
    start_in = 1'b1;
    key_in   = key;
    tick();
    start_in = 1'b0;
    cycles   = 1;
    check("valid_drop", keys_valid_out, 1'b0);
    check("busy_set", busy_out, 1'b1);
    while (!done_out && cycles < 3000) begin
      if (inj_round > 0 && n_starts == inj_round && !injected) begin
        start_in = 1'b1;
        key_in   = inj_key;
        injected = 1'b1;
      end else begin
        start_in = 1'b0;
      end
      tick();
      cycles++;
    end
    start_in = 1'b0;
    check("done_seen", done_out, 1'b1);
    exp_lat = 1;
    foreach (lat_q[i]) exp_lat += lat_q[i] + 2;
    check("latency", cycles, exp_lat);
    check("valid_at_done", keys_valid_out, 1'b1);
    check("busy_at_done", busy_out, 1'b0);
    check("n_rounds", n_starts, 10);
    for (int i = 0; i < n_starts && i < 10; i++) check("rcon", rcon_q[i], i);
    if (done_poke) start_in = 1'b1;
    tick();
    start_in = 1'b0;
    if (done_poke) check("done_start_ignored", busy_out, 1'b0);
    check("done_low", done_out, 1'b0);
    check("done_pulses", n_done, 1);
    check("no_error", n_err, 0);
    for (int a = 0; a <= 10; a++) begin
      read_key(4'(a), got);
      check("round_key", got, ks[a]);
    end
  endtask

  typedef struct {
    logic [127:0] key;
    logic [3:0]   addr;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] cur_key, got, k;
    bit have_key;
    int g, t;

    vecs[0] = '{128'h5468617473206D79204B756E67204675, 4'd0, 128'h5468617473206D79204B756E67204675};
    vecs[1] = '{128'h5468617473206D79204B756E67204675, 4'd1, 128'hE232FCF191129188B159E4E6D679A293};
    vecs[2] = '{128'h5468617473206D79204B756E67204675, 4'd10, 128'h28FDDEF86DA4244ACCC0A4FE3B316F26};
    vecs[3] = '{128'h5468617473206D79204B756E67204675, 4'd11, 128'h0};
    vecs[4] = '{128'h5468617473206D79204B756E67204675, 4'd15, 128'h0};
    vecs[5] = '{128'h2B7E151628AED2A6ABF7158809CF4F3C, 4'd10, 128'hD014F9A8C9EE2589E13F0CC8B6630CA6};
    vecs[6] = '{128'h2B7E151628AED2A6ABF7158809CF4F3C, 4'd0, 128'h2B7E151628AED2A6ABF7158809CF4F3C};

    // Reset values.
    #1;
    check("rst_busy", busy_out, 1'b0);
    check("rst_done", done_out, 1'b0);
    check("rst_valid", keys_valid_out, 1'b0);
    check("rst_error", error_out, 1'b0);
    check("rst_exp_start", exp_start_out, 1'b0);
    check("rst_rcon", exp_rcon_out, 4'd0);
    check("rst_exp_key", exp_key_out, 128'h0);
    check("rst_rd_key", rd_key_out, 128'h0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Engine ready outside WAIT must be ignored.
    clear_counts();
    eng_mode = 2;
    repeat (3) tick();
    check("idle_ready_busy", busy_out, 1'b0);
    check("idle_ready_done", n_done, 0);
    eng_mode = 1;
    tick();

    // Known-answer vectors.
    have_key = 1'b0;
    cur_key  = '0;
    for (int i = 0; i < 7; i++) begin
      if (!have_key || vecs[i].key != cur_key) begin
        full_check(vecs[i].key, 0, '0, (i == 5));
        cur_key  = vecs[i].key;
        have_key = 1'b1;
      end
      read_key(vecs[i].addr, got);
      check("kat_read", got, vecs[i].exp);
    end

    // Second start during round 4 is ignored.
    full_check(128'h000102030405060708090A0B0C0D0E0F, 4,
               128'hFFEEDDCCBBAA99887766554433221100, 1'b0);

    // Engine that never answers.
    clear_counts();
    eng_mode = 0;
    start_in = 1'b1;
    key_in   = {$urandom, $urandom, $urandom, $urandom};
    tick();
    start_in = 1'b0;
    g = 0;
    while (!exp_start_out && g < 10) begin tick(); g++; end
    check("timeout_issue_seen", exp_start_out, 1'b1);
    t = 0;
    while (!error_out && t < TO + 20) begin tick(); t++; end
    check("timeout_cycles", t, TO);
    check("timeout_busy", busy_out, 1'b0);
    check("timeout_valid", keys_valid_out, 1'b0);
    check("timeout_no_done", n_done, 0);
    tick();
    check("error_pulse_low", error_out, 1'b0);
    check("error_count", n_err, 1);
    eng_mode = 1;
    full_check({$urandom, $urandom, $urandom, $urandom}, 0, '0, 1'b0);

    // Reset during round 6.
    clear_counts();
    start_in = 1'b1;
    key_in   = {$urandom, $urandom, $urandom, $urandom};
    tick();
    start_in = 1'b0;
    g = 0;
    while (n_starts < 6 && g < 500) begin tick(); g++; end
    check("reached_round6", n_starts, 6);
    reset_n = 1'b0;
    #1;
    check("abort_busy", busy_out, 1'b0);
    check("abort_valid", keys_valid_out, 1'b0);
    check("abort_exp_start", exp_start_out, 1'b0);
    check("abort_rcon", exp_rcon_out, 4'd0);
    check("abort_exp_key", exp_key_out, 128'h0);
    check("abort_rd_key", rd_key_out, 128'h0);
    repeat (2) tick();
    check("abort_no_done", n_done, 0);
    check("abort_no_error", n_err, 0);
    reset_n = 1'b1;
    tick();
    full_check({$urandom, $urandom, $urandom, $urandom}, 0, '0, 1'b0);

    // Randomized keys and engine latencies, plus random reads.
    for (int n = 0; n < 6; n++) begin
      logic [127:0] ks [11];
      logic [3:0] a;
      lat_max = int'($urandom_range(4, 1));
      k = {$urandom, $urandom, $urandom, $urandom};
      full_check(k, 0, '0, 1'b0);
      ks[0] = k;
      for (int r = 1; r <= 10; r++) ks[r] = next_key(ks[r-1], 4'(r - 1));
      for (int j = 0; j < 4; j++) begin
        a = 4'($urandom_range(15, 0));
        read_key(a, got);
        check("rand_read", got, (a <= 4'd10) ? ks[a] : 128'h0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
